move_link_rx: RTL and testbench

MOVE_LINK_RX -- requirements
Module: move_link_rx

---
 rtl/move_link_rx.sv | 145 ++++++++++++++
 tb/tb_move_link_rx.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_link_rx.sv
// move_link_rx: receives 2-bit move frames from the remote board over an async serial line.
// Build option: define MOVE_LINK_PARITY_EN to add an odd-parity bit after d1.
module move_link_rx #(
    parameter int BIT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic link_data,
    output logic left_pulse,
    output logic right_pulse,
    output logic put_pulse,
    output logic frame_err,
    output logic busy
);
    // state  | meaning
    // IDLE   | waiting for a falling edge on sd while enabled
    // START  | half-bit wait, then confirm the start bit is still low
    // DATA   | sample d0, then d1
    // PARITY | sample the parity bit (parity build only)
    // STOP   | sample the stop bit and judge the frame

    localparam int CW = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] CNT_FULL = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(BIT_CYCLES / 2 - 1);

`ifdef MOVE_LINK_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      sync_q;
    logic            sd, sd_prev_q;
    logic            bit_idx_q, bit_idx_d;
    logic [1:0]      data_q, data_d;
    logic            par_ok, frame_ok;
    logic [3:0]      rslt_q, rslt_d;
    logic [3:0]      pulse_q;

    assign sd = sync_q[1];

`ifdef MOVE_LINK_PARITY_EN
    logic par_q, par_d;
    assign par_ok = ^{data_q, par_q};
`else
    assign par_ok = 1'b1;
`endif

    assign frame_ok = sd && (data_q != 2'b00) && par_ok;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
`ifdef MOVE_LINK_PARITY_EN
        par_d     = par_q;
`endif
        rslt_d    = 4'b0000;
        if (state_q == S_IDLE) begin
            if (enable && !sd && sd_prev_q) begin
                state_d = S_START;
                cnt_d   = CNT_HALF;
            end
        end else if (!enable) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end else begin
            cnt_d = CNT_FULL;
            case (state_q)
                S_START: begin
                    bit_idx_d = 1'b0;
                    state_d   = sd ? S_IDLE : S_DATA;
                end
                S_DATA: begin
                    data_d[bit_idx_q] = sd;
                    bit_idx_d         = 1'b1;
                    if (bit_idx_q) begin
`ifdef MOVE_LINK_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
`ifdef MOVE_LINK_PARITY_EN
                S_PARITY: begin
                    par_d   = sd;
                    state_d = S_STOP;
                end
`endif
                S_STOP: begin
                    state_d = S_IDLE;
                    if (frame_ok) begin
                        rslt_d = {1'b0, data_q == 2'b11, data_q == 2'b10, data_q == 2'b01};
                    end else begin
                        rslt_d = 4'b1000;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // The verdict is staged once more so the pulse lands one cycle after the FSM is back in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sync_q    <= 2'b11;
            sd_prev_q <= 1'b1;
            bit_idx_q <= 1'b0;
            data_q    <= 2'b00;
`ifdef MOVE_LINK_PARITY_EN
            par_q     <= 1'b0;
`endif
            rslt_q    <= 4'b0000;
            pulse_q   <= 4'b0000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sync_q    <= {sync_q[0], link_data};
            sd_prev_q <= sd;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
`ifdef MOVE_LINK_PARITY_EN
            par_q     <= par_d;
`endif
            rslt_q    <= rslt_d;
            pulse_q   <= rslt_q;
        end
    end

    assign left_pulse  = pulse_q[0];
    assign right_pulse = pulse_q[1];
    assign put_pulse   = pulse_q[2];
    assign frame_err   = pulse_q[3];
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_move_link_rx.sv
// Bench for move_link_rx: directed frames plus random frames judged by a frame-level model.
// Event kinds: 0 left, 1 right, 2 put, 3 frame_err.
module tb_move_link_rx;
    localparam int BC = 4;
`ifdef MOVE_LINK_PARITY_EN
    localparam int NB = 4;
`else
    localparam int NB = 3;
`endif
    localparam int LAT      = BC / 2 + NB * BC + 1;
    localparam int SYNC_DLY = 3;

    logic clk, rst, enable, link_data;
    logic left_pulse, right_pulse, put_pulse, frame_err, busy;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int ev_cyc[$];
    int ev_kind[$];
    int exp_cyc[$];
    int exp_kind[$];
    int start_q[$];
    int bz_rise[$];
    int bz_fall[$];
    logic busy_prev = 1'b0;
    bit multi_hi = 1'b0;

    move_link_rx #(.BIT_CYCLES(BC)) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .link_data(link_data),
        .left_pulse(left_pulse),
        .right_pulse(right_pulse),
        .put_pulse(put_pulse),
        .frame_err(frame_err),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if ((int'(left_pulse) + int'(right_pulse) + int'(put_pulse) + int'(frame_err)) > 1) multi_hi = 1'b1;
        if (left_pulse)  begin ev_cyc.push_back(cyc); ev_kind.push_back(0); end
        if (right_pulse) begin ev_cyc.push_back(cyc); ev_kind.push_back(1); end
        if (put_pulse)   begin ev_cyc.push_back(cyc); ev_kind.push_back(2); end
        if (frame_err)   begin ev_cyc.push_back(cyc); ev_kind.push_back(3); end
        if (busy && !busy_prev) bz_rise.push_back(cyc);
        if (!busy && busy_prev) bz_fall.push_back(cyc);
        busy_prev = busy;
    end

    // Reference: a frame yields its move only with a high stop bit, a legal code and odd parity.
    function automatic int expected_kind(input logic d0, input logic d1, input logic p, input logic st);
        int code;
        bit par_ok;
        code   = int'({d1, d0});
        par_ok = (NB == 3) || ((d0 ^ d1 ^ p) == 1'b1);
        if (st && code != 0 && par_ok) return code - 1;
        return 3;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        link_data = b;
        cycles(BC);
    endtask

    task automatic clear_logs();
        ev_cyc.delete(); ev_kind.delete();
        exp_cyc.delete(); exp_kind.delete();
        start_q.delete(); bz_rise.delete(); bz_fall.delete();
        multi_hi = 1'b0;
    endtask

    task automatic send_frame(input logic d0, input logic d1, input logic p, input logic st, input int gap_bits);
        int t;
        t = cyc;
        start_q.push_back(t);
        exp_cyc.push_back(t + SYNC_DLY + LAT);
        exp_kind.push_back(expected_kind(d0, d1, p, st));
        drive_bit(1'b0);
        drive_bit(d0);
        drive_bit(d1);
        if (NB == 4) drive_bit(p);
        drive_bit(st);
        for (int i = 0; i < gap_bits; i++) drive_bit(1'b1);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({left_pulse, right_pulse, put_pulse, frame_err, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 00000", {left_pulse, right_pulse, put_pulse, frame_err, busy});
        end
        rst = 1'b1;
        cycles(2 * BC);
        checks++;
        if (busy !== 1'b0 || ev_kind.size() != 0) begin
            errors++;
            $display("FAIL reset_release_idle: busy %b events %0d, expected busy 0 events 0", busy, ev_kind.size());
        end
    endtask

    task automatic test_left();
        clear_logs();
        send_frame(1'b1, 1'b0, 1'b0, 1'b1, 2);
        checks++;
        if (bz_rise.size() != 1 || bz_rise[0] != start_q[0] + SYNC_DLY) begin
            errors++;
            $display("FAIL left_start_time: got %0d busy rises (first at %0d), expected 1 at %0d",
                     bz_rise.size(), (bz_rise.size() > 0) ? bz_rise[0] : -1, start_q[0] + SYNC_DLY);
        end
        checks++;
        if (ev_kind.size() != exp_kind.size()) begin
            errors++;
            $display("FAIL left count: got %0d events, expected %0d", ev_kind.size(), exp_kind.size());
        end
        for (int i = 0; i < exp_kind.size() && i < ev_kind.size(); i++) begin
            checks++;
            if (ev_kind[i] !== exp_kind[i] || ev_cyc[i] !== exp_cyc[i]) begin
                errors++;
                $display("FAIL left event %0d: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                         i, ev_kind[i], ev_cyc[i], exp_kind[i], exp_cyc[i]);
            end
        end
    endtask

    task automatic test_put_bad_parity();
        clear_logs();
        send_frame(1'b1, 1'b1, 1'b1, 1'b1, 1);
        send_frame(1'b0, 1'b0, 1'b1, 1'b1, 2);
        checks++;
        if (ev_kind.size() != exp_kind.size()) begin
            errors++;
            $display("FAIL put_parity count: got %0d events, expected %0d", ev_kind.size(), exp_kind.size());
        end
        for (int i = 0; i < exp_kind.size() && i < ev_kind.size(); i++) begin
            checks++;
            if (ev_kind[i] !== exp_kind[i] || ev_cyc[i] !== exp_cyc[i]) begin
                errors++;
                $display("FAIL put_parity event %0d: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                         i, ev_kind[i], ev_cyc[i], exp_kind[i], exp_cyc[i]);
            end
        end
    endtask

    task automatic test_right_bad_stop();
        clear_logs();
        send_frame(1'b0, 1'b1, 1'b0, 1'b1, 1);
        send_frame(1'b0, 1'b1, 1'b0, 1'b0, 2);
        checks++;
        if (ev_kind.size() != exp_kind.size()) begin
            errors++;
            $display("FAIL right_stop count: got %0d events, expected %0d", ev_kind.size(), exp_kind.size());
        end
        for (int i = 0; i < exp_kind.size() && i < ev_kind.size(); i++) begin
            checks++;
            if (ev_kind[i] !== exp_kind[i] || ev_cyc[i] !== exp_cyc[i]) begin
                errors++;
                $display("FAIL right_stop event %0d: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                         i, ev_kind[i], ev_cyc[i], exp_kind[i], exp_cyc[i]);
            end
        end
    endtask

    task automatic test_glitch();
        int t;
        clear_logs();
        t = cyc;
        link_data = 1'b0;
        cycles(1);
        link_data = 1'b1;
        cycles(4 * BC);
        checks++;
        if (ev_kind.size() != 0) begin
            errors++;
            $display("FAIL glitch_outputs: got %0d events, expected 0", ev_kind.size());
        end
        checks++;
        if (bz_rise.size() != 1 || bz_fall.size() != 1 ||
            bz_rise[0] != t + SYNC_DLY || bz_fall[0] != t + SYNC_DLY + BC / 2) begin
            errors++;
            $display("FAIL glitch_busy: got %0d rises %0d falls (rise %0d fall %0d), expected rise %0d fall %0d",
                     bz_rise.size(), bz_fall.size(), (bz_rise.size() > 0) ? bz_rise[0] : -1,
                     (bz_fall.size() > 0) ? bz_fall[0] : -1, t + SYNC_DLY, t + SYNC_DLY + BC / 2);
        end
    endtask

    task automatic test_enable_drop();
        int t;
        clear_logs();
        t = cyc;
        drive_bit(1'b0);
        drive_bit(1'b1);
        enable = 1'b0;
        drive_bit(1'b0);
        if (NB == 4) drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        enable = 1'b1;
        cycles(2 * BC);
        checks++;
        if (bz_fall.size() != 1 || bz_fall[0] != t + 2 * BC + 1) begin
            errors++;
            $display("FAIL enable_drop_busy: got %0d falls (first %0d), expected 1 at %0d",
                     bz_fall.size(), (bz_fall.size() > 0) ? bz_fall[0] : -1, t + 2 * BC + 1);
        end
        checks++;
        if (ev_kind.size() != 0) begin
            errors++;
            $display("FAIL enable_drop_outputs: got %0d events, expected 0", ev_kind.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_logs();
        drive_bit(1'b0);
        drive_bit(1'b1);
        rst = 1'b0;
        #1;
        checks++;
        if ({left_pulse, right_pulse, put_pulse, frame_err, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %b expected 00000", {left_pulse, right_pulse, put_pulse, frame_err, busy});
        end
        link_data = 1'b1;
        cycles(2);
        rst = 1'b1;
        cycles(6 * BC);
        checks++;
        if (ev_kind.size() != 0 || bz_rise.size() != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_after: got %0d events %0d busy rises busy %b, expected 0 events 1 rise busy 0",
                     ev_kind.size(), bz_rise.size(), busy);
        end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        send_frame(1'b1, 1'b0, 1'b0, 1'b1, 1);
        send_frame(1'b0, 1'b1, 1'b0, 1'b1, 1);
        send_frame(1'b1, 1'b1, 1'b1, 1'b1, 2);
        checks++;
        if (ev_kind.size() != exp_kind.size() || multi_hi) begin
            errors++;
            $display("FAIL back_to_back count: got %0d events (overlap %0d), expected %0d",
                     ev_kind.size(), multi_hi, exp_kind.size());
        end
        for (int i = 0; i < exp_kind.size() && i < ev_kind.size(); i++) begin
            checks++;
            if (ev_kind[i] !== exp_kind[i] || ev_cyc[i] !== exp_cyc[i]) begin
                errors++;
                $display("FAIL back_to_back event %0d: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                         i, ev_kind[i], ev_cyc[i], exp_kind[i], exp_cyc[i]);
            end
        end
    endtask

    task automatic test_random();
        clear_logs();
        for (int n = 0; n < 30; n++) begin
            send_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 7) != 0), int'($urandom_range(1, 3)));
        end
        cycles(2 * BC);
        checks++;
        if (ev_kind.size() != exp_kind.size() || multi_hi) begin
            errors++;
            $display("FAIL random count: got %0d events (overlap %0d), expected %0d",
                     ev_kind.size(), multi_hi, exp_kind.size());
        end
        for (int i = 0; i < exp_kind.size() && i < ev_kind.size(); i++) begin
            checks++;
            if (ev_kind[i] !== exp_kind[i] || ev_cyc[i] !== exp_cyc[i]) begin
                errors++;
                $display("FAIL random event %0d: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                         i, ev_kind[i], ev_cyc[i], exp_kind[i], exp_cyc[i]);
            end
        end
        checks++;
        if (bz_rise.size() != start_q.size()) begin
            errors++;
            $display("FAIL random starts: got %0d busy rises, expected %0d", bz_rise.size(), start_q.size());
        end
        for (int i = 0; i < start_q.size() && i < bz_rise.size(); i++) begin
            checks++;
            if (bz_rise[i] != start_q[i] + SYNC_DLY) begin
                errors++;
                $display("FAIL random start %0d: got busy rise at %0d, expected %0d", i, bz_rise[i], start_q[i] + SYNC_DLY);
            end
        end
    endtask

    initial begin
        rst       = 1'b0;
        enable    = 1'b1;
        link_data = 1'b1;
        test_reset();
        test_left();
        test_put_bad_parity();
        test_right_bad_stop();
        test_glitch();
        test_enable_drop();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
